audio_fifo_writer: RTL

Producer-side block for the audio sample FIFO that the Nios II subsystem drains through its FIFO PIOs (q/rdempty/rdfull/rdreq). It captures stereo samples from the audio front end, packs each left/right pair into one 32-bit word, and writes exactly one frame of `FRAME_LEN` words into the FIFO write port per request. Requests come from the Nios `data_back` PIO line. FIFO-full conditions are handled by dropping samples and counting the drops, so the Nios always receives complete frames for FFT processing.

---
 rtl/audio_fifo_writer.sv | 101 ++++++++++
 1 files changed

// File: rtl/audio_fifo_writer.sv
// audio_fifo_writer
// Captures stereo sample pairs, packs each pair as {left, right} and writes
// exactly FRAME_LEN words into the audio FIFO per rising edge of frame_req.
// Samples that arrive while the FIFO is full are dropped and counted, so a
// frame is stretched in time but never shortened in content.
module audio_fifo_writer #(
    parameter int unsigned FRAME_LEN    = 256,
    parameter int unsigned SAMPLE_WIDTH = 16
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic [SAMPLE_WIDTH-1:0]     sample_left,
    input  logic [SAMPLE_WIDTH-1:0]     sample_right,
    input  logic                        sample_valid,
    input  logic                        frame_req,
    input  logic                        fifo_wrfull,
    output logic [2*SAMPLE_WIDTH-1:0]   fifo_data,
    output logic                        fifo_wrreq,
    output logic                        busy,
    output logic                        frame_done,
    output logic [15:0]                 overflow_count
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE,
        S_CAPTURE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               r_req_prev;

    logic               w_req_edge;
    logic               w_accept;
    logic               w_drop;
    logic               w_last;

    // Request edge and per-sample accept/drop decisions for this cycle
    always_comb begin
        w_req_edge = frame_req & ~r_req_prev;
        w_accept   = (r_state == S_CAPTURE) & sample_valid & ~fifo_wrfull;
        w_drop     = (r_state == S_CAPTURE) & sample_valid &  fifo_wrfull;
        w_last     = w_accept & (r_word_cnt == LAST_IDX);
    end

    // Frame FSM with registered FIFO write port and status outputs.
    // req_prev resets high so a request held through reset does not start a frame.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state        <= S_IDLE;
            r_word_cnt     <= '0;
            r_req_prev     <= 1'b1;
            fifo_data      <= '0;
            fifo_wrreq     <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            overflow_count <= '0;
        end else begin
            r_req_prev <= frame_req;
            fifo_wrreq <= 1'b0;
            frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_req_edge) begin
                        r_state        <= S_CAPTURE;
                        busy           <= 1'b1;
                        r_word_cnt     <= '0;
                        overflow_count <= '0;
                    end
                end

                S_CAPTURE: begin
                    if (w_accept) begin
                        fifo_data  <= {sample_left, sample_right};
                        fifo_wrreq <= 1'b1;
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (w_last) begin
                            r_state    <= S_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end else if (w_drop) begin
                        if (overflow_count != '1) begin
                            overflow_count <= overflow_count + 16'd1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
